// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable bit period, width and parity, feeding a
// small first-word-fall-through FIFO with sticky framing/parity/overrun flags.
module uart_rx_fifo #(
    parameter int unsigned CLK_DIV    = 2604,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RX,
    input  logic                 rd_en,
    input  logic                 clr_err,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_rdy,
    output logic                 fifo_full,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int unsigned HALF  = CLK_DIV / 2;
    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic                 rx_meta, rx_s;
    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 par_bad_c;
    logic                 push_c, frame_set_c, par_set_c;

    // Two-flop synchroniser; the line idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
        end
    end

    assign par_bad_c = ((^shreg_q) ^ par_q) != 1'(PARITY_ODD);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        push_c      = 1'b0;
        frame_set_c = 1'b0;
        par_set_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                // Mid-start check rejects short low glitches
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(DATA_BITS - 1))
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Leave at mid-stop so a following start edge is not missed
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        frame_set_c = 1'b1;
                        state_d     = S_BREAK;
                    end else if ((PARITY_EN != 0) && par_bad_c) begin
                        par_set_c = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        push_c  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic                 pop_c, full_c, wr_c, ovr_c;
    logic [DATA_BITS-1:0] head_d;

    assign pop_c  = rd_en & rx_rdy;
    assign full_c = occ_q == OCC_W'(FIFO_DEPTH);
    assign wr_c   = push_c & (~full_c | pop_c);
    assign ovr_c  = push_c & full_c & ~pop_c;

    always_comb begin
        occ_d = occ_q;
        if (wr_c && !pop_c)
            occ_d = occ_q + OCC_W'(1);
        else if (!wr_c && pop_c)
            occ_d = occ_q - OCC_W'(1);
        rd_ptr_d = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        // Bypass the incoming word when it lands at the new head slot
        head_d = (wr_c && (wr_ptr_q == rd_ptr_d)) ? shreg_q : mem[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (wr_c) mem[wr_ptr_q] <= shreg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            rx_data   <= '0;
            rx_rdy    <= 1'b0;
            fifo_full <= 1'b0;
        end else begin
            if (wr_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            if (occ_d != '0) rx_data <= head_d;
            rx_rdy    <= occ_d != '0;
            fifo_full <= occ_d == OCC_W'(FIFO_DEPTH);
        end
    end

    // Sticky flags; a same-cycle set beats clr_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= frame_set_c | (frame_err & ~clr_err);
            parity_err <= par_set_c | (parity_err & ~clr_err);
            overrun    <= ovr_c | (overrun & ~clr_err);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames plus random traffic, checked every
// cycle against a queue-based model of the receiver and FIFO.
module tb_uart_rx_fifo;

    localparam int unsigned CLK_DIV    = 16;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned PARITY_EN  = 1;
    localparam int unsigned PARITY_ODD = 0;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned HALF       = CLK_DIV / 2;
    // Falling edge of start to the edge that pushes: 2 sync flops, 1 detect,
    // half a bit, then one full bit per data/parity/stop sample.
    localparam int LAT = 3 + int'(HALF) + int'((DATA_BITS + PARITY_EN + 1) * CLK_DIV);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RX = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rx_data;
    logic       rx_rdy, fifo_full, frame_err, parity_err, overrun;

    uart_rx_fifo #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .PARITY_EN(PARITY_EN),
        .PARITY_ODD(PARITY_ODD), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .rd_en(rd_en), .clr_err(clr_err),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .fifo_full(fifo_full),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [7:0] word;
        int         kind;   // 0 good, 1 parity error, 2 framing error
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] model_q[$];
    bit         m_frame, m_par, m_ovr;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    bit         rnd_mode = 0;
    int         rd_rate = 0;
    bit         rd_next = 0;
    bit         clr_next = 0;
    bit         chk_on = 0;
    int         rise_cyc = -1;
    bit         prev_rdy = 0;
    int         t0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    function automatic void model_clear();
        model_q.delete();
        ev_q.delete();
        m_frame = 0;
        m_par   = 0;
        m_ovr   = 0;
    endfunction

    // One clock edge of the model: pop, frame outcomes due now, flag update
    function automatic void model_step(input int now);
        bit full, pop, sf, sp, so;
        full = model_q.size() == int'(FIFO_DEPTH);
        pop  = (rd_en === 1'b1) && (model_q.size() != 0);
        sf = 0; sp = 0; so = 0;
        if (pop) void'(model_q.pop_front());
        while (ev_q.size() != 0 && ev_q[0].at == now) begin
            case (ev_q[0].kind)
                0: if (full && !pop) so = 1; else model_q.push_back(ev_q[0].word);
                1: sp = 1;
                default: sf = 1;
            endcase
            void'(ev_q.pop_front());
        end
        m_frame = sf | (m_frame & !clr_err);
        m_par   = sp | (m_par & !clr_err);
        m_ovr   = so | (m_ovr & !clr_err);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_clear();
        else begin
            model_step(cyc + 1);
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("rx_rdy", 32'(rx_rdy), 32'(model_q.size() != 0));
            check("fifo_full", 32'(fifo_full), 32'(model_q.size() == int'(FIFO_DEPTH)));
            check("frame_err", 32'(frame_err), 32'(m_frame));
            check("parity_err", 32'(parity_err), 32'(m_par));
            check("overrun", 32'(overrun), 32'(m_ovr));
            if (model_q.size() != 0) check("rx_data", 32'(rx_data), 32'(model_q[0]));
            if (rx_rdy && !prev_rdy) rise_cyc <= cyc;
            prev_rdy <= rx_rdy;
        end
    end

    task automatic tick(input logic v);
        @(posedge clk);
        #1;
        RX      = v;
        rd_en   = rd_next | (rnd_mode && (int'($urandom_range(0, 7)) < rd_rate));
        clr_err = clr_next | (rnd_mode && ($urandom_range(0, 31) == 0));
        rd_next  = 0;
        clr_next = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input bit clr_at_stop, input bit rd_at_stop, output int start);
        logic [10:0] bits;
        int k;
        int kind;
        bits = {s, p, d, 1'b0};
        kind = (s == 1'b0) ? 2 : (((^d) ^ p) != 1'(PARITY_ODD)) ? 1 : 0;
        k = 0;
        start = 0;
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < int'(CLK_DIV); c++) begin
                if (k == LAT - 1) begin
                    if (clr_at_stop) clr_next = 1;
                    if (rd_at_stop) rd_next = 1;
                end
                tick(bits[b]);
                if (k == 0) begin
                    start = cyc;
                    ev_q.push_back('{at: cyc + LAT, word: d, kind: kind});
                end
                k++;
            end
        end
    endtask

    task automatic pop_expect(input string name, input logic [7:0] w);
        check(name, 32'(rx_data), 32'(w));
        rd_next = 1;
        tick(1'b1);
        tick(1'b1);
    endtask

    initial begin
        logic [7:0] d;
        logic       p, s;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_rdy", 32'(rx_rdy), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_flags", 32'({frame_err, parity_err, overrun}), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        chk_on = 1;
        idle(4);

        // 0xA5 has four ones, so even parity bit is 0
        send_frame(8'hA5, 1'b0, 1'b1, 0, 0, t0);
        check("a5_latency", 32'(rise_cyc - t0), 32'd171);
        check("a5_data", 32'(rx_data), 32'hA5);
        rd_next = 1;
        tick(1'b1);
        tick(1'b1);
        check("a5_popped", 32'(rx_rdy), 32'd0);
        idle(4);

        repeat (5) tick(1'b0);
        idle(2 * CLK_DIV);
        check("glitch_rdy", 32'(rx_rdy), 32'd0);
        check("glitch_flags", 32'({frame_err, parity_err, overrun}), 32'd0);

        send_frame(8'h07, 1'b1, 1'b1, 0, 0, t0);
        idle(3);
        send_frame(8'h07, 1'b0, 1'b1, 0, 0, t0);
        idle(3);
        check("par_err_set", 32'(parity_err), 32'd1);
        pop_expect("par_good_word", 8'h07);
        check("par_fifo_empty", 32'(rx_rdy), 32'd0);
        clr_next = 1;
        idle(2);

        send_frame(8'h3C, 1'b0, 1'b0, 0, 0, t0);
        check("brk_frame_err", 32'(frame_err), 32'd1);
        for (int i = 0; i < 100 * int'(CLK_DIV); i++) begin
            if (i == 800) clr_next = 1;
            tick(1'b0);
        end
        check("brk_single_err", 32'(frame_err), 32'd0);
        check("brk_no_push", 32'(rx_rdy), 32'd0);
        idle(CLK_DIV);
        send_frame(8'h55, 1'b0, 1'b1, 0, 0, t0);
        idle(2);
        pop_expect("after_brk", 8'h55);

        for (int w = 1; w <= 5; w++) begin
            d = 8'(w);
            send_frame(d, ^d, 1'b1, 0, 0, t0);
            idle(2);
            if (w == 4) check("ovf_full4", 32'(fifo_full), 32'd1);
        end
        check("ovf_overrun", 32'(overrun), 32'd1);
        pop_expect("ovf_pop1", 8'h01);
        pop_expect("ovf_pop2", 8'h02);
        pop_expect("ovf_pop3", 8'h03);
        pop_expect("ovf_pop4", 8'h04);
        check("ovf_empty", 32'(rx_rdy), 32'd0);
        clr_next = 1;
        idle(2);

        for (int w = 1; w <= 5; w++) begin
            d = 8'(w);
            send_frame(d, ^d, 1'b1, 0, w == 5, t0);
            idle(2);
        end
        check("pp_no_overrun", 32'(overrun), 32'd0);
        pop_expect("pp_pop2", 8'h02);
        pop_expect("pp_pop3", 8'h03);
        pop_expect("pp_pop4", 8'h04);
        pop_expect("pp_pop5", 8'h05);

        send_frame(8'h81, 1'b0, 1'b0, 1, 0, t0);
        check("clr_vs_set", 32'(frame_err), 32'd1);
        idle(CLK_DIV);
        clr_next = 1;
        idle(2);

        send_frame(8'h5A, 1'b0, 1'b1, 0, 0, t0);
        idle(2);
        repeat (40) tick(1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", 32'(rx_rdy), 32'd0);
        check("mid_rst_full", 32'(fifo_full), 32'd0);
        check("mid_rst_flags", 32'({frame_err, parity_err, overrun}), 32'd0);
        check("mid_rst_data", 32'(rx_data), 32'd0);
        RX = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2 * CLK_DIV);
        send_frame(8'hC3, 1'b0, 1'b1, 0, 0, t0);
        idle(2);
        pop_expect("post_rst", 8'hC3);

        rnd_mode = 1;
        for (int f = 0; f < 40; f++) begin
            rd_rate = int'($urandom_range(0, 4));
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, HALF - 1)) tick(1'b0);
                idle(CLK_DIV);
            end
            d = 8'($urandom);
            p = ($urandom_range(0, 7) != 0) ? ^d : ~(^d);
            s = ($urandom_range(0, 7) != 0);
            send_frame(d, p, s, 0, 0, t0);
            if (!s) idle(CLK_DIV);
            else idle(int'($urandom_range(0, 3)));
        end
        rnd_mode = 0;
        idle(CLK_DIV);
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor to the team's fixed 8N1 UART receiver.
- Configurable bit period, data width and optional parity.
- Start-bit glitch rejection, stop-bit framing check and break handling.
- Received words buffer in a small first-word-fall-through FIFO, so the command/control logic can drain them at its own pace.
- Sits between the serial RX pin and the command processor.

Parameters:
CLK_DIV, 2604, clk cycles per bit (>= 4); HALF = CLK_DIV/2, integer division
DATA_BITS, 8, data bits per frame (5..9), LSB first
PARITY_EN, 0, 1 = a parity bit follows the data
PARITY_ODD, 0, 1 = odd parity, 0 = even (used only when PARITY_EN = 1)
FIFO_DEPTH, 4, receive FIFO entries (power of 2, >= 2)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
RX  input  1  asynchronous serial line, idle high
rd_en  input  1  pop the FIFO head; ignored when rx_rdy = 0
clr_err  input  1  clears all sticky error flags
rx_data  output  DATA_BITS  FIFO head word; valid while rx_rdy = 1
rx_rdy  output  1  FIFO not empty
fifo_full  output  1  FIFO holds FIFO_DEPTH words
frame_err  output  1  sticky: stop bit sampled low
parity_err  output  1  sticky: parity mismatch
overrun  output  1  sticky: good frame arrived while FIFO full

Behaviour:
Reset values:
- rx_rdy = 0, fifo_full = 0, all error flags = 0, FIFO empty.
- rx_data = 0.
- Synchroniser flops = 1; state = IDLE.

Synchroniser and timing:
- RX passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
- A baud counter clears on IDLE->START and after every sample point, and increments otherwise.

State machine:
- IDLE: on rx_s = 0, go to START and clear the counter.
- START: when the counter reaches HALF-1, sample rx_s.
  - rx_s = 1: glitch; return to IDLE with no flags set.
  - rx_s = 0: go to DATA.
- DATA: sample every CLK_DIV cycles. Shift the sample into the MSB of a DATA_BITS register, shifting right.
  - After DATA_BITS samples, go to PARITY if PARITY_EN = 1, else to STOP.
- PARITY: sample one bit. Mismatch occurs when the XOR of data and parity bit is not equal to PARITY_ODD.
- STOP: sample one bit, then:
  - rx_s = 0: set frame_err, discard the word, go to BREAK.
  - Parity mismatch: set parity_err, discard the word, go to IDLE.
  - Otherwise: push the word and go to IDLE in the same cycle. The mid-stop return allows back-to-back frames.
- BREAK: stay until rx_s = 1, then go to IDLE. A held-low line produces exactly one frame_err.

FIFO:
- First-word fall-through: rx_data always shows the head.
- A push makes rx_rdy rise on the next clk.
- rd_en with rx_rdy = 1 pops; the next word is visible on the next clk.
- Push while full without a same-cycle pop: set overrun and drop the new word. Contents are unchanged.
- Push and pop in the same cycle while full: both occur, no overrun.
- Push and pop in the same cycle while holding 1 word: rx_rdy stays 1 and the new word appears.
- Read and write pointers wrap modulo FIFO_DEPTH. An occupancy counter of log2(FIFO_DEPTH)+1 bits drives rx_rdy and fifo_full.

Error flags:
- Sticky until clr_err.
- If set and clr_err happen in the same cycle, the flag is set (set wins).

Reset mid-frame:
- Abort immediately, flush the FIFO, and return all outputs to their reset values.

Test Plan:
- CLK_DIV=16, 8N1, send 0xA5 -> rx_rdy rises 1 clk after the mid-stop sample; rx_data = 0xA5. Pulse rd_en -> rx_rdy = 0 next clk.
- CLK_DIV=16: drive RX low for 5 cycles, then high -> START aborts, no push, no flags, state returns to IDLE.
- PARITY_EN=1, PARITY_ODD=0:
  - Send 0x07 with parity 1 -> word 0x07 pushed.
  - Send 0x07 with parity 0 -> parity_err = 1, FIFO unchanged.
- Send 0x3C with stop bit 0, then hold RX low for 100 bit times -> exactly one frame_err, no push. After RX returns high, the next frame 0x55 is received correctly.
- FIFO_DEPTH=4: send 0x01..0x05 without reading -> fifo_full after the 4th word, overrun = 1 on the 5th. Pops return 0x01..0x04.
- Repeat with a rd_en pulse coincident with the 5th push -> no overrun; pops return 0x02..0x05.
- Assert clr_err in the same cycle as a new frame_err -> frame_err stays 1. Assert rst_n low mid-DATA -> all outputs at reset values, FIFO empty.
